// File: rtl/filter_pkg.sv
// Shared definitions for the filter chain: parity-word type, stage function
// and count-width helper.
package filter_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    // Data word plus its parity/carry bit, sized for the widest supported chain.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic                 parity;
    } pword_t;

    // Rotate-left through parity over the low `width` bits; upper bits are zeroed.
    function automatic pword_t filter_rotate(input pword_t w, input int unsigned width);
        pword_t               r;
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] msb;
        mask     = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        msb      = MAX_WIDTH'(1) << (width - 1);
        r.data   = ((w.data << 1) | MAX_WIDTH'(w.parity)) & mask;
        r.parity = |(w.data & msb);
        return r;
    endfunction

    // Width of the occupancy count: holds 0 .. stages+1.
    function automatic int unsigned count_width(input int unsigned stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/filter_chain_if.sv
// Valid/ready stream carrying a data word and a parity/carry bit.
interface filter_chain_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             parity;
    logic             valid;
    logic             ready;

    modport master (output data, output parity, output valid, input ready);
    modport slave  (input data, input parity, input valid, output ready);
endinterface

// File: rtl/filter_stage.sv
// One registered rotate-through-parity stage with its own valid bit.
module filter_stage
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_parity,
    input  logic             dn_rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             parity
);
    logic   rdy;
    pword_t src_w;
    pword_t nxt;

    // Load enable: an empty stage always loads, a full one only when downstream moves.
    always_comb rdy = !valid | dn_rdy;

    // Stage function on the incoming word.
    always_comb begin
        src_w.data   = MAX_WIDTH'(src_data);
        src_w.parity = src_parity;
        nxt          = filter_rotate(src_w, WIDTH);
    end

    if (WIDTH < MAX_WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = |nxt.data[MAX_WIDTH-1:WIDTH];
    end

    // Valid follows the source on every load; payload only captures valid words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            data   <= '0;
            parity <= 1'b0;
        end else if (rdy) begin
            valid <= src_valid;
            if (src_valid) begin
                data   <= nxt.data[WIDTH-1:0];
                parity <= nxt.parity;
            end
        end
    end

endmodule

// File: rtl/filter_chain.sv
// STAGES-deep rotate-through-parity pipeline with valid/ready backpressure
// and an occupancy count. Define FILTER_CHAIN_SKID_EN to add a one-entry
// input skid register that decouples io_x.ready from io_y.ready.
module filter_chain
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    filter_chain_if.slave                    io_x,
    filter_chain_if.master                   io_y,
    output logic [count_width(STAGES)-1:0]   io_count
);
    localparam int unsigned CW = count_width(STAGES);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] p;
    logic [WIDTH-1:0]  d [STAGES];
    logic              rdy0;
    logic              s0_valid;
    logic [WIDTH-1:0]  s0_data;
    logic              s0_parity;
    logic              skid_cnt;

    // Stage 0 can load unless every stage is full and the consumer stalls.
    always_comb rdy0 = io_y.ready | ~(&v);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic             src_p;
        logic             dn;

        if (k == 0) begin : g_head
            assign src_v = s0_valid;
            assign src_d = s0_data;
            assign src_p = s0_parity;
        end else begin : g_body
            assign src_v = v[k-1];
            assign src_d = d[k-1];
            assign src_p = p[k-1];
        end

        // rdy_{k+1} unrolled from the valid bits, so no combinational chain through stages.
        if (k == STAGES - 1) begin : g_tail
            assign dn = io_y.ready;
        end else begin : g_mid
            assign dn = io_y.ready | ~(&v[STAGES-1:k+1]);
        end

        filter_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .src_valid  (src_v),
            .src_data   (src_d),
            .src_parity (src_p),
            .dn_rdy     (dn),
            .valid      (v[k]),
            .data       (d[k]),
            .parity     (p[k])
        );
    end

`ifdef FILTER_CHAIN_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_parity;

    // Ready is the registered skid state; a held skid word feeds stage 0 first.
    always_comb begin
        io_x.ready = !skid_valid;
        s0_valid   = skid_valid | io_x.valid;
        s0_data    = skid_valid ? skid_data   : io_x.data;
        s0_parity  = skid_valid ? skid_parity : io_x.parity;
        skid_cnt   = skid_valid;
    end

    // Capture an accepted word that stage 0 cannot take; release it when stage 0 loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_parity <= 1'b0;
        end else if (skid_valid) begin
            if (rdy0) begin
                skid_valid <= 1'b0;
            end
        end else if (io_x.valid && !rdy0) begin
            skid_valid  <= 1'b1;
            skid_data   <= io_x.data;
            skid_parity <= io_x.parity;
        end
    end
`else
    // Input feeds stage 0 directly; ready is the stage-0 load enable.
    always_comb begin
        io_x.ready = rdy0;
        s0_valid   = io_x.valid;
        s0_data    = io_x.data;
        s0_parity  = io_x.parity;
        skid_cnt   = 1'b0;
    end
`endif

    // Last stage drives the output stream.
    always_comb begin
        io_y.valid  = v[STAGES-1];
        io_y.data   = d[STAGES-1];
        io_y.parity = p[STAGES-1];
    end

    // Occupancy: valid stages plus the skid entry.
    always_comb begin
        io_count = CW'(skid_cnt);
        for (int unsigned i = 0; i < STAGES; i++) begin
            io_count = io_count + CW'(v[i]);
        end
    end

endmodule

// File: tb/tb_filter_chain.sv
// Directed bench for filter_chain: a WIDTH=16/STAGES=2 instance and a
// WIDTH=8/STAGES=4 instance, checked against a rotate-of-{parity,data} model.
module tb_filter_chain;

    localparam int unsigned AW = 16;
    localparam int unsigned AS = 2;
    localparam int unsigned BW = 8;
    localparam int unsigned BS = 4;
`ifdef FILTER_CHAIN_SKID_EN
    localparam int unsigned A_FULL = 3;
`else
    localparam int unsigned A_FULL = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_chain_if #(.WIDTH(AW)) a_x ();
    filter_chain_if #(.WIDTH(AW)) a_y ();
    filter_chain_if #(.WIDTH(BW)) b_x ();
    filter_chain_if #(.WIDTH(BW)) b_y ();
    logic [1:0] a_count;
    logic [2:0] b_count;

    filter_chain #(.WIDTH(AW), .STAGES(AS)) u_a (
        .clk(clk), .reset(rst), .io_x(a_x), .io_y(a_y), .io_count(a_count)
    );
    filter_chain #(.WIDTH(BW), .STAGES(BS)) u_b (
        .clk(clk), .reset(rst), .io_x(b_x), .io_y(b_y), .io_count(b_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {parity,data} rotated left by one bit per stage.
    function automatic logic [16:0] model_a(input logic [15:0] dd, input logic pp);
        logic [16:0] w;
        w = {pp, dd};
        for (int i = 0; i < int'(AS); i++) w = {w[15:0], w[16]};
        return w;
    endfunction

    function automatic logic [8:0] model_b(input logic [7:0] dd, input logic pp);
        logic [8:0] w;
        w = {pp, dd};
        for (int i = 0; i < int'(BS); i++) w = {w[7:0], w[8]};
        return w;
    endfunction

    logic [16:0] q_a[$];
    logic [8:0]  q_b[$];
    logic        a_hold = 1'b0;
    logic [16:0] a_prev = '0;
    logic        b_hold = 1'b0;
    logic [8:0]  b_prev = '0;

    task automatic step_a(input logic xv, input logic [15:0] xd, input logic xp,
                          input logic yr, output logic acc);
        @(negedge clk);
        a_x.valid = xv; a_x.data = xd; a_x.parity = xp; a_y.ready = yr;
        #1;
        check("a_count", 32'(a_count), q_a.size());
        if (q_a.size() == 0) check("a_empty_valid", 32'(a_y.valid), 0);
        if (a_hold) begin
            check("a_hold_valid", 32'(a_y.valid), 1);
            check("a_hold_word", 32'({a_y.parity, a_y.data}), 32'(a_prev));
        end
        if (a_y.valid && yr && q_a.size() != 0)
            check("a_out", 32'({a_y.parity, a_y.data}), 32'(q_a.pop_front()));
        a_hold = a_y.valid && !yr;
        a_prev = {a_y.parity, a_y.data};
        acc = xv && a_x.ready;
        if (acc) q_a.push_back(model_a(xd, xp));
    endtask

    task automatic step_b(input logic xv, input logic [7:0] xd, input logic xp,
                          input logic yr, output logic acc);
        @(negedge clk);
        b_x.valid = xv; b_x.data = xd; b_x.parity = xp; b_y.ready = yr;
        #1;
        check("b_count", 32'(b_count), q_b.size());
        if (q_b.size() == 0) check("b_empty_valid", 32'(b_y.valid), 0);
        if (b_hold) begin
            check("b_hold_valid", 32'(b_y.valid), 1);
            check("b_hold_word", 32'({b_y.parity, b_y.data}), 32'(b_prev));
        end
        if (b_y.valid && yr && q_b.size() != 0)
            check("b_out", 32'({b_y.parity, b_y.data}), 32'(q_b.pop_front()));
        b_hold = b_y.valid && !yr;
        b_prev = {b_y.parity, b_y.data};
        acc = xv && b_x.ready;
        if (acc) q_b.push_back(model_b(xd, xp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          sent;
        logic [15:0] words [8];
        logic [15:0] stall_w [6];
        words   = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h0F0F, 16'h7FFE, 16'h8421};
        stall_w = '{16'h1001, 16'h2002, 16'h4004, 16'h8008, 16'hC00C, 16'hE00E};

        rst = 1'b1;
        a_x.valid = 0; a_x.data = '0; a_x.parity = 0; a_y.ready = 0;
        b_x.valid = 0; b_x.data = '0; b_x.parity = 0; b_y.ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_y_valid", 32'(a_y.valid), 0);
        check("rst_y_data", 32'(a_y.data), 0);
        check("rst_y_parity", 32'(a_y.parity), 0);
        check("rst_count", 32'(a_count), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_x_ready", 32'(a_x.ready), 1);

        // Single words: latency and stage function.
        step_a(1, 16'h8001, 0, 1, acc);
        check("t1_accept", 32'(acc), 1);
        step_a(0, '0, 0, 1, acc);
        check("t1_not_early", 32'(a_y.valid), 0);
        step_a(0, '0, 0, 1, acc);
        check("t1_valid", 32'(a_y.valid), 1);
        check("t1_data", 32'(a_y.data), 32'h0005);
        check("t1_parity", 32'(a_y.parity), 0);

        step_a(1, 16'hC000, 1, 1, acc);
        step_a(0, '0, 0, 1, acc);
        step_a(0, '0, 0, 1, acc);
        check("t2_valid", 32'(a_y.valid), 1);
        check("t2_data", 32'(a_y.data), 32'h0003);
        check("t2_parity", 32'(a_y.parity), 1);

        // Back-to-back stream at full rate.
        for (int i = 0; i < 10; i++) begin
            step_a(i < 8, words[i % 8], 1'(i), 1, acc);
            if (i < 8) check("b2b_accept", 32'(acc), 1);
            if (i >= 2) check("b2b_valid", 32'(a_y.valid), 1);
            if (i >= 2 && i <= 8) check("b2b_count", 32'(a_count), 2);
        end

        // Stall with the consumer blocked, then release.
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            step_a(1, stall_w[sent], 1'(sent), 0, acc);
            if (acc) sent++;
        end
        step_a(1, stall_w[sent], 1'(sent), 0, acc);
        check("stall_accepts", 32'(sent), A_FULL);
        check("stall_x_ready", 32'(a_x.ready), 0);
        check("stall_count", 32'(a_count), A_FULL);
        if (acc) sent++;
        for (int c = 0; c < 40; c++) begin
            step_a(sent < 6, stall_w[sent % 6], 1'(sent), 1, acc);
            if (acc) sent++;
            if (sent == 6 && q_a.size() == 0) break;
        end
        check("stall_all_sent", 32'(sent), 6);
        check("stall_drained", q_a.size(), 0);

        // Asynchronous reset with words in flight.
        step_a(1, 16'h00F0, 1, 0, acc);
        step_a(1, 16'h0F00, 0, 0, acc);
        a_x.valid = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_y_valid", 32'(a_y.valid), 0);
        check("mid_rst_count", 32'(a_count), 0);
        check("mid_rst_y_data", 32'(a_y.data), 0);
        q_a.delete();
        a_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step_a(1, 16'h0001, 0, 1, acc);
        step_a(0, '0, 0, 1, acc);
        step_a(0, '0, 0, 1, acc);
        check("post_rst_valid", 32'(a_y.valid), 1);
        check("post_rst_data", 32'(a_y.data), 32'h0004);
        check("post_rst_parity", 32'(a_y.parity), 0);
        repeat (3) step_a(0, '0, 0, 1, acc);

        // Deeper, narrower chain under irregular valid/ready.
        for (int c = 0; c < 3000; c++) begin
            step_b($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                   $urandom_range(0, 2) != 0, acc);
        end
        for (int c = 0; c < 60; c++) begin
            step_b(0, '0, 0, 1, acc);
            if (q_b.size() == 0) break;
        end
        check("b_drained", q_b.size(), 0);
        step_b(0, '0, 0, 1, acc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
